// File: rtl/bp_pkg.sv
// bp_pkg: shared types and saturating-counter helpers for the branch predictor.
//   bp_mode_e : PHT indexing scheme (BIMODAL, GSHARE)
//   ctr_init  : weakly-not-taken reset value for a counter of 'bits' width
//   ctr_next  : saturating +1 (taken) / -1 (not taken) for a counter of 'bits' width
// Counters are carried in a CTR_MAX_W-bit container so one function serves every
// legal CTR_BITS (1..4); callers zero-extend on entry and truncate on return.
package bp_pkg;

   typedef enum logic {
      BIMODAL = 1'b0,
      GSHARE  = 1'b1
   } bp_mode_e;

   localparam int CTR_MAX_W = 4;

   function automatic logic [CTR_MAX_W-1:0] ctr_init(input int bits);
      return CTR_MAX_W'((1 << (bits - 1)) - 1);
   endfunction

   function automatic logic [CTR_MAX_W-1:0] ctr_next(input logic [CTR_MAX_W-1:0] ctr,
                                                     input logic                 taken,
                                                     input int                   bits);
      logic [CTR_MAX_W-1:0] ctr_max;
      ctr_max = CTR_MAX_W'((1 << bits) - 1);
      if (taken) begin
         return (ctr == ctr_max) ? ctr : ctr + 1'b1;
      end
      return (ctr == '0) ? ctr : ctr - 1'b1;
   endfunction

endpackage

// File: rtl/bp_sat_ctr_array.sv
// bp_sat_ctr_array: pattern history table of ENTRIES saturating counters.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (all counters -> weakly not taken)
//   rd_idx / rd_ctr   : combinational read port (returns pre-update contents)
//   wr_en, wr_idx     : single write port, applied at the rising edge
//   wr_taken          : direction of the saturating step (1 = +1, 0 = -1)
module bp_sat_ctr_array
   import bp_pkg::*;
#(
   parameter int ENTRIES  = 64,
   parameter int CTR_BITS = 2,
   parameter int IDX      = $clog2(ENTRIES)
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IDX-1:0]      rd_idx,
   output logic [CTR_BITS-1:0] rd_ctr,
   input  logic                wr_en,
   input  logic [IDX-1:0]      wr_idx,
   input  logic                wr_taken
);

   logic [CTR_BITS-1:0] ctr_q [ENTRIES];
   logic [CTR_BITS-1:0] ctr_d [ENTRIES];

   always_comb begin
      ctr_d = ctr_q;
      if (wr_en) begin
         ctr_d[wr_idx] = CTR_BITS'(ctr_next(CTR_MAX_W'(ctr_q[wr_idx]), wr_taken, CTR_BITS));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= CTR_BITS'(ctr_init(CTR_BITS));
         end
      end else begin
         ctr_q <= ctr_d;
      end
   end

   assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB + PHT direction predictor for the RV32I fetch stage.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   pc_f, lookup_en_f               : fetch PC and fetch-not-stalled qualifier
//   pred_taken_f/target_f/idx_f     : same-cycle prediction and the PHT index used
//   upd_*_e, pred_taken_e/target_e  : resolved branch/jump from EX with its carried prediction
//   flush_all                       : invalidate every BTB entry
//   mispredict_e, redirect_pc_e     : combinational redirect request and correct next PC
//   lookups, mispredicts            : free-running, wrapping performance counters
module branch_predictor
   import bp_pkg::*;
#(
   parameter int  XLEN      = 32,
   parameter int  ENTRIES   = 64,
   parameter int  CTR_BITS  = 2,
   parameter int  MODE      = 0,
   parameter int  HIST_BITS = 6,
   localparam int IDX       = $clog2(ENTRIES)
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc_f,
   output logic            pred_taken_f,
   output logic [XLEN-1:0] pred_target_f,
   output logic [IDX-1:0]  pred_idx_f,
   input  logic            lookup_en_f,
   input  logic            upd_valid_e,
   input  logic [XLEN-1:0] upd_pc_e,
   input  logic            upd_jump_e,
   input  logic            upd_taken_e,
   input  logic [XLEN-1:0] upd_target_e,
   input  logic [IDX-1:0]  upd_idx_e,
   input  logic            pred_taken_e,
   input  logic [XLEN-1:0] pred_target_e,
   input  logic            flush_all,
   output logic            mispredict_e,
   output logic [XLEN-1:0] redirect_pc_e,
   output logic [31:0]     lookups,
   output logic [31:0]     mispredicts
);

   localparam int       TAG_W  = XLEN - IDX - 2;
   localparam bp_mode_e MODE_E = (MODE == 1) ? GSHARE : BIMODAL;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  target;
      logic             jump;
   } btb_entry_t;

   // Valid bits carry the reset; tag/target/jump are plain storage that only
   // matters once the matching valid bit is set.
   logic [ENTRIES-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]    tag_q    [ENTRIES];
   logic [XLEN-1:0]     target_q [ENTRIES];
   logic [ENTRIES-1:0]  jump_q;
   logic [HIST_BITS-1:0] ghr_q, ghr_d;
   logic [31:0]         lookups_q, lookups_d;
   logic [31:0]         mispredicts_q, mispredicts_d;

   logic [IDX-1:0]      f_btb_idx;
   btb_entry_t          f_entry;
   logic                f_hit;
   logic [CTR_BITS-1:0] f_ctr;

   logic [IDX-1:0]      e_btb_idx;
   logic                e_branch;
   logic                btb_we;
   btb_entry_t          wr_entry_d;

   // ---------------- fetch-side lookup (combinational) ----------------
   assign f_btb_idx = pc_f[IDX+1:2];

   always_comb begin
      f_entry.valid  = valid_q[f_btb_idx];
      f_entry.tag    = tag_q[f_btb_idx];
      f_entry.target = target_q[f_btb_idx];
      f_entry.jump   = jump_q[f_btb_idx];
   end

   assign f_hit         = f_entry.valid && (f_entry.tag == pc_f[XLEN-1:IDX+2]);
   assign pred_idx_f    = (MODE_E == GSHARE) ? (f_btb_idx ^ IDX'(ghr_q)) : f_btb_idx;
   assign pred_taken_f  = f_hit & (f_entry.jump | f_ctr[CTR_BITS-1]);
   assign pred_target_f = pred_taken_f ? f_entry.target : pc_f + XLEN'(4);

   bp_sat_ctr_array #(
      .ENTRIES  (ENTRIES),
      .CTR_BITS (CTR_BITS),
      .IDX      (IDX)
   ) u_pht (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (pred_idx_f),
      .rd_ctr   (f_ctr),
      .wr_en    (e_branch),
      .wr_idx   (upd_idx_e),
      .wr_taken (upd_taken_e)
   );

   // ---------------- execute-side resolution (combinational) ----------------
   assign mispredict_e  = upd_valid_e & ((upd_taken_e != pred_taken_e) |
                                         (upd_taken_e & (upd_target_e != pred_target_e)));
   assign redirect_pc_e = upd_taken_e ? upd_target_e : upd_pc_e + XLEN'(4);

   assign e_btb_idx = upd_pc_e[IDX+1:2];
   assign e_branch  = upd_valid_e & ~upd_jump_e;
   // Only taken outcomes allocate; a concurrent flush drops the write.
   assign btb_we    = upd_valid_e & upd_taken_e & ~flush_all;

   always_comb begin
      wr_entry_d.valid  = 1'b1;
      wr_entry_d.tag    = upd_pc_e[XLEN-1:IDX+2];
      wr_entry_d.target = upd_target_e;
      wr_entry_d.jump   = upd_jump_e;

      valid_d = valid_q;
      if (btb_we) begin
         valid_d[e_btb_idx] = wr_entry_d.valid;
      end
      if (flush_all) begin
         valid_d = '0;
      end

      // History is shifted with resolved outcomes only, so it never needs repair.
      ghr_d = ghr_q;
      if ((MODE_E == GSHARE) && e_branch) begin
         ghr_d = HIST_BITS'({ghr_q, upd_taken_e});
      end

      lookups_d     = lookups_q + 32'(lookup_en_f);
      mispredicts_d = mispredicts_q + 32'(mispredict_e);
   end

   // ---------------- state update ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q       <= '0;
         ghr_q         <= '0;
         lookups_q     <= '0;
         mispredicts_q <= '0;
      end else begin
         valid_q       <= valid_d;
         ghr_q         <= ghr_d;
         lookups_q     <= lookups_d;
         mispredicts_q <= mispredicts_d;
      end
   end

   always_ff @(posedge clk) begin
      if (btb_we) begin
         tag_q[e_btb_idx]    <= wr_entry_d.tag;
         target_q[e_btb_idx] <= wr_entry_d.target;
         jump_q[e_btb_idx]   <= wr_entry_d.jump;
      end
   end

   assign lookups     = lookups_q;
   assign mispredicts = mispredicts_q;

endmodule
